// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and shifts it out
// one bit per enabled cycle with registered frame and last-bit markers.
module byte_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             ser_last,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_ser_out;
   logic             r_ser_frame;
   logic             r_ser_last;

   logic             w_cnt_last;
   logic             w_accept;
   logic             w_cur_bit;
   logic [WIDTH-1:0] w_shift_next;

   assign w_cnt_last = (r_bit_cnt == LastCnt);
   assign d_ready    = (r_state == StIdle) || (ser_en && w_cnt_last);
   assign w_accept   = d_valid && d_ready;
   assign busy       = (r_state == StShift);
   assign ser_out    = r_ser_out;
   assign ser_frame  = r_ser_frame;
   assign ser_last   = r_ser_last;

   always_comb begin
      w_cur_bit    = 1'b0;
      w_shift_next = r_shift;
      if (MSB_FIRST) begin
         w_cur_bit    = r_shift[WIDTH-1];
         w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      end else begin
         w_cur_bit    = r_shift[0];
         w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_ser_out   <= 1'b0;
         r_ser_frame <= 1'b0;
         r_ser_last  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_ser_out   <= 1'b0;
               r_ser_frame <= 1'b0;
               r_ser_last  <= 1'b0;
               if (w_accept) begin
                  r_shift   <= d;
                  r_bit_cnt <= '0;
                  r_state   <= StShift;
               end
            end
            StShift: begin
               // ser_en low freezes every piece of serial state
               if (ser_en) begin
                  r_ser_out   <= w_cur_bit;
                  r_ser_frame <= 1'b1;
                  r_ser_last  <= w_cnt_last;
                  if (w_cnt_last) begin
                     r_bit_cnt <= '0;
                     if (w_accept) begin
                        r_shift <= d;
                     end else begin
                        r_shift <= w_shift_next;
                        r_state <= StIdle;
                     end
                  end else begin
                     r_shift   <= w_shift_next;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: an MSB-first and an LSB-first instance share
// clock and reset; a vector table plus hand-written multi-cycle sequences.
module tb_byte_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] d_m, d_l;
   logic       v_m, v_l;
   logic       en_m, en_l;
   logic       rdy_m, rdy_l;
   logic       out_m, out_l;
   logic       frm_m, frm_l;
   logic       lst_m, lst_l;
   logic       bsy_m, bsy_l;

   int checks;
   int failures;

   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk       (clk),
      .rst       (rst),
      .d         (d_m),
      .d_valid   (v_m),
      .d_ready   (rdy_m),
      .ser_en    (en_m),
      .ser_out   (out_m),
      .ser_frame (frm_m),
      .ser_last  (lst_m),
      .busy      (bsy_m)
   );

   byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk       (clk),
      .rst       (rst),
      .d         (d_l),
      .d_valid   (v_l),
      .d_ready   (rdy_l),
      .ser_en    (en_l),
      .ser_out   (out_l),
      .ser_frame (frm_l),
      .ser_last  (lst_l),
      .busy      (bsy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       msb;
      logic [7:0] data;
      logic [7:0] seq;  // expected bits, seq[7] appears first
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic msb, input logic [7:0] data, input logic valid);
      if (msb) begin
         d_m = data;
         v_m = valid;
      end else begin
         d_l = data;
         v_l = valid;
      end
   endtask

   function automatic logic g_out(input logic msb);
      return msb ? out_m : out_l;
   endfunction
   function automatic logic g_frm(input logic msb);
      return msb ? frm_m : frm_l;
   endfunction
   function automatic logic g_lst(input logic msb);
      return msb ? lst_m : lst_l;
   endfunction
   function automatic logic g_bsy(input logic msb);
      return msb ? bsy_m : bsy_l;
   endfunction
   function automatic logic g_rdy(input logic msb);
      return msb ? rdy_m : rdy_l;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Eight enabled bits of one word, starting from the edge after the accept
   task automatic expect_bits(input logic msb, input logic [7:0] seq, input string tag);
      for (int i = 0; i < 8; i++) begin
         step();
         check({tag, " ser_out"}, 32'(g_out(msb)), 32'(seq[7-i]));
         check({tag, " ser_frame"}, 32'(g_frm(msb)), 32'd1);
         check({tag, " ser_last"}, 32'(g_lst(msb)), 32'(i == 7));
      end
   endtask

   task automatic expect_idle(input logic msb, input string tag);
      step();
      check({tag, " idle frame"}, 32'(g_frm(msb)), 32'd0);
      check({tag, " idle last"}, 32'(g_lst(msb)), 32'd0);
      check({tag, " idle busy"}, 32'(g_bsy(msb)), 32'd0);
      check({tag, " idle ready"}, 32'(g_rdy(msb)), 32'd1);
   endtask

   task automatic send(input logic msb, input logic [7:0] data, input logic [7:0] seq,
                       input string tag);
      drive(msb, data, 1'b1);
      check({tag, " ready idle"}, 32'(g_rdy(msb)), 32'd1);
      step();
      // d must be ignored after the accept
      drive(msb, ~data, 1'b0);
      check({tag, " busy"}, 32'(g_bsy(msb)), 32'd1);
      check({tag, " frame before first bit"}, 32'(g_frm(msb)), 32'd0);
      expect_bits(msb, seq, tag);
      expect_idle(msb, tag);
   endtask

   initial begin
      logic [7:0] s;
      checks   = 0;
      failures = 0;
      rst  = 1'b1;
      d_m  = 8'h00;
      d_l  = 8'h00;
      v_m  = 1'b0;
      v_l  = 1'b0;
      en_m = 1'b1;
      en_l = 1'b1;

      vecs[0] = '{msb: 1'b1, data: 8'hA5, seq: 8'hA5};
      vecs[1] = '{msb: 1'b0, data: 8'h01, seq: 8'h80};
      vecs[2] = '{msb: 1'b1, data: 8'h3C, seq: 8'h3C};
      vecs[3] = '{msb: 1'b0, data: 8'h0F, seq: 8'hF0};
      vecs[4] = '{msb: 1'b0, data: 8'h12, seq: 8'h48};
      vecs[5] = '{msb: 1'b1, data: 8'h01, seq: 8'h01};

      repeat (2) step();
      check("reset ser_out", 32'(out_m), 32'd0);
      check("reset ser_frame", 32'(frm_m), 32'd0);
      check("reset ser_last", 32'(lst_m), 32'd0);
      check("reset busy", 32'(bsy_m), 32'd0);
      check("reset ready", 32'(rdy_m), 32'd1);
      check("reset lsb frame", 32'(frm_l), 32'd0);
      #2 rst = 1'b0;
      step();

      for (int k = 0; k < 6; k++) begin
         send(vecs[k].msb, vecs[k].data, vecs[k].seq, $sformatf("vec%0d", k));
      end

      // Back-to-back FF then 00 with d_valid held high
      drive(1'b1, 8'hFF, 1'b1);
      step();
      drive(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check("b2b ready", 32'(rdy_m), 32'(i % 8 == 7));
         step();
         if (i == 7) drive(1'b1, 8'h00, 1'b0);
         check("b2b ser_out", 32'(out_m), 32'(i < 8));
         check("b2b frame", 32'(frm_m), 32'd1);
         check("b2b last", 32'(lst_m), 32'(i % 8 == 7));
      end
      expect_idle(1'b1, "b2b");

      // Stall for three cycles after the third bit of C3
      drive(1'b1, 8'hC3, 1'b1);
      step();
      drive(1'b1, 8'h00, 1'b0);
      s = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall pre bit", 32'(out_m), 32'(s[7-i]));
      end
      en_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall ready", 32'(rdy_m), 32'd0);
         step();
         check("stall hold out", 32'(out_m), 32'd0);
         check("stall hold frame", 32'(frm_m), 32'd1);
         check("stall hold last", 32'(lst_m), 32'd0);
      end
      en_m = 1'b1;
      for (int i = 3; i < 8; i++) begin
         step();
         check("stall post bit", 32'(out_m), 32'(s[7-i]));
         check("stall post frame", 32'(frm_m), 32'd1);
         check("stall post last", 32'(lst_m), 32'(i == 7));
      end
      expect_idle(1'b1, "stall");

      // Asynchronous reset after four bits of 5A
      drive(1'b1, 8'h5A, 1'b1);
      step();
      drive(1'b1, 8'h00, 1'b0);
      s = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         step();
         check("arst pre bit", 32'(out_m), 32'(s[7-i]));
      end
      check("arst pre frame", 32'(frm_m), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst frame", 32'(frm_m), 32'd0);
      check("arst out", 32'(out_m), 32'd0);
      check("arst busy", 32'(bsy_m), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("arst ready", 32'(rdy_m), 32'd1);
      check("arst busy rel", 32'(bsy_m), 32'd0);
      step();
      check("arst no resume", 32'(frm_m), 32'd0);
      send(1'b1, 8'h81, 8'h81, "arst new");

      // d_valid raised while busy is held off until the last-bit edge
      drive(1'b1, 8'h96, 1'b1);
      step();
      drive(1'b1, 8'hE7, 1'b1);
      s = 8'h96;
      for (int i = 0; i < 8; i++) begin
         check("hold ready", 32'(rdy_m), 32'(i == 7));
         step();
         if (i == 7) drive(1'b1, 8'h00, 1'b0);
         check("hold first bit", 32'(out_m), 32'(s[7-i]));
      end
      expect_bits(1'b1, 8'hE7, "hold second");
      expect_idle(1'b1, "hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
